// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared by the EX-stage decoder and the multiply sequencer,
// plus the multiply sequencer state type.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul(input logic [2:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand/multiplier shift registers and the
// partial-product accumulator. Sequencing is owned by mul_sequencer.
module mul_shift_add_dp
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // Sum for the current step; wraps modulo 2^WIDTH, which is the wanted low half.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i) begin
    if (clear) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= data1_i;
      mplier <= data2_i;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage iterative multiply controller: runs a WIDTH-step shift-add loop for
// MUL and holds the pipeline until the product is registered on result_o.
module mul_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic             post_rst;
  logic             trigger;
  logic             dp_clear;
  logic             dp_load;
  logic             dp_step;
  logic [WIDTH-1:0] acc_next;

  // The cycle after reset never starts a multiply, so stall_o stays low there.
  assign trigger  = start_i && is_mul(ALUCtrl_i) && !flush_i && !post_rst;

  assign dp_clear = rst_i || flush_i;
  assign dp_load  = (state == IDLE) && trigger;
  assign dp_step  = (state == RUN);

  assign stall_o  = !rst_i && !flush_i &&
                    (((state == IDLE) && trigger) || (state == RUN));
  assign busy_o   = !rst_i && (state == RUN);
  assign done_o   = !rst_i && (state == DONE);

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i    (clk_i),
    .clear    (dp_clear),
    .load     (dp_load),
    .step     (dp_step),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      post_rst <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (trigger) begin
              state <= RUN;
              cnt   <= '0;
            end
          end
          RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              result_o <= acc_next;
              state    <= DONE;
            end
          end
          // The stalled MUL is still in EX here; start_i must not retrigger.
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: cycle-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul_sequencer;
  import alu_ctrl_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   ALUCtrl_i = ALU_NOP;
  logic         flush_i = 1'b0;
  logic [W-1:0] data1_i = '0;
  logic [W-1:0] data2_i = '0;
  logic         stall_o, busy_o, done_o;
  logic [W-1:0] result_o;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ALUCtrl_i (ALUCtrl_i),
    .flush_i   (flush_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: age counts cycles into the current multiply (0 = none, 1..W = running,
  // W+1 = product-ready cycle).
  int           age = 0;
  logic [W-1:0] m_prod = '0;
  logic [W-1:0] m_result = '0;

  logic         obs_stall, obs_done;
  logic [W-1:0] obs_result;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    logic trig, e_stall, e_busy, e_done;
    @(negedge clk);
    trig    = start_i && (ALUCtrl_i == ALU_MUL) && !flush_i && (age == 0);
    e_stall = !rst_i && !flush_i && (trig || (age >= 1 && age <= W));
    e_busy  = !rst_i && (age >= 1 && age <= W);
    e_done  = !rst_i && (age == W + 1);
    cmp("stall", W'(stall_o), W'(e_stall));
    cmp("busy",  W'(busy_o),  W'(e_busy));
    cmp("done",  W'(done_o),  W'(e_done));
    cmp("result", result_o, m_result);
    obs_stall  = stall_o;
    obs_done   = done_o;
    obs_result = result_o;
    @(posedge clk);
    if (rst_i) begin
      age = 0;
      m_result = '0;
    end else if (flush_i) begin
      age = 0;
    end else if (age == 0) begin
      if (trig) begin
        age = 1;
        m_prod = data1_i * data2_i;
      end
    end else if (age <= W) begin
      age++;
      if (age == W + 1) m_result = m_prod;
    end else begin
      age = 0;
    end
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] ctrl, input logic fl,
                       input logic rs, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = st; ALUCtrl_i = ctrl; flush_i = fl; rst_i = rs;
    data1_i = a; data2_i = b;
  endtask

  // Issue a MUL held in EX while stalled. abort_kind: 0 none, 1 flush, 2 reset at cycle abort_at.
  task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int abort_kind, input int abort_at,
                        output int stalls, output int done_at, output logic [W-1:0] res);
    int limit;
    stalls = 0; done_at = -1; res = 'x;
    limit = (abort_kind == 0) ? 40 : abort_at + 4;
    for (int c = 0; c < limit && done_at < 0; c++) begin
      if (abort_kind != 0 && c == abort_at)
        drive(1'b1, ALU_MUL, abort_kind == 1, abort_kind == 2, a, b);
      else if (abort_kind != 0 && c > abort_at)
        drive(1'b0, ALU_NOP, 1'b0, 1'b0, '0, '0);
      else
        drive(1'b1, ALU_MUL, 1'b0, 1'b0, a, b);
      cycle();
      if (obs_stall) stalls++;
      if (obs_done) begin done_at = c; res = obs_result; end
    end
    if (abort_kind != 0) res = obs_result;
  endtask

  int           st, dn, abs0;
  logic [W-1:0] r;

  initial begin
    // Reset held: outputs quiet, result cleared.
    drive(1'b1, ALU_MUL, 1'b0, 1'b1, 32'd3, 32'd5);
    @(posedge clk); #1;
    cycle();
    cycle();
    cmp("reset_result", obs_result, 32'd0);
    drive(1'b0, ALU_NOP, 1'b0, 1'b0, '0, '0);
    cycle();

    // Basic 3*5.
    mul_op(32'd3, 32'd5, 0, 0, st, dn, r);
    cmp("basic_stalls", W'(st), 32'd33);
    cmp("basic_done_cycle", W'(dn), 32'd33);
    cmp("basic_result", r, 32'd15);

    // Single-cycle ops: no stall, result untouched.
    drive(1'b1, ALU_ADD, 1'b0, 1'b0, 32'd7, 32'd8); cycle();
    cmp("add_stall", W'(obs_stall), 32'd0);
    drive(1'b1, ALU_OR, 1'b0, 1'b0, 32'd7, 32'd8);  cycle();
    drive(1'b1, ALU_NOP, 1'b0, 1'b0, 32'd7, 32'd8); cycle();
    cmp("nop_result_kept", obs_result, 32'd15);

    // Flush in RUN cycle 10.
    mul_op(32'd7, 32'd9, 1, 10, st, dn, r);
    cmp("flush_stalls", W'(st), 32'd10);
    cmp("flush_no_done", W'(dn), 32'hFFFF_FFFF);
    cmp("flush_result_kept", r, 32'd15);

    // Wrap-around.
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, st, dn, r);
    cmp("wrap_ff_result", r, 32'h0000_0001);
    mul_op(32'h8000_0000, 32'd2, 0, 0, st, dn, r);
    cmp("wrap_80_result", r, 32'h0000_0000);

    // Back-to-back: second MUL enters EX right after DONE.
    mul_op(32'd2, 32'd3, 0, 0, st, dn, r);
    cmp("b2b_first_done", W'(dn), 32'd33);
    cmp("b2b_first_result", r, 32'd6);
    abs0 = dn + 1;
    mul_op(32'd4, 32'd4, 0, 0, st, dn, r);
    cmp("b2b_second_done", W'(abs0 + dn), 32'd67);
    cmp("b2b_second_result", r, 32'd16);

    // Reset in RUN cycle 5, then a fresh multiply.
    mul_op(32'd3, 32'd5, 2, 5, st, dn, r);
    cmp("rst_stalls", W'(st), 32'd5);
    cmp("rst_no_done", W'(dn), 32'hFFFF_FFFF);
    cmp("rst_result_cleared", r, 32'd0);
    mul_op(32'd3, 32'd5, 0, 0, st, dn, r);
    cmp("post_rst_done_cycle", W'(dn), 32'd33);
    cmp("post_rst_result", r, 32'd15);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic         s, f, rs;
      logic [2:0]   ctrl;
      logic [W-1:0] a, b;
      rs   = ($urandom_range(0, 399) == 0);
      s    = ($urandom_range(0, 3) != 0);
      ctrl = ($urandom_range(0, 1) == 0) ? ALU_MUL : 3'($urandom_range(0, 7));
      f    = ($urandom_range(0, 59) == 0) && (age != W + 1);
      case ($urandom_range(0, 5))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'd0;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? 32'h8000_0001 : $urandom;
      if (rst_i) s = 1'b0;
      drive(s, ctrl, f, rs, a, b);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply controller for the EX stage of the 5-stage pipeline. When the instruction in EX carries ALU control code MUL (3'b101), the block captures both operands, runs a WIDTH-cycle shift-add loop, and holds the pipeline via `stall_o` until the product is ready. Single-cycle ALU operations (ADD/SUB/AND/OR) pass through untouched with no stall. The hazard unit ORs `stall_o` into its PC/IF-ID/ID-EX write-disable. The EX result mux selects `result_o` on `done_o`.

## Interface
- `WIDTH`, 32, operand and product width; the product is the low WIDTH bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  EX stage holds a valid instruction this cycle.
- `ALUCtrl_i`  in  3  ALU control code of the EX instruction.
- `flush_i`  in  1  EX instruction is squashed; abort any multiply in progress.
- `data1_i`  in  WIDTH  multiplicand (rs value).
- `data2_i`  in  WIDTH  multiplier (rt value).
- `stall_o`  out  1  pipeline hold request.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse; `result_o` holds a new product.
- `result_o`  out  WIDTH  last completed product, registered.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - Trigger: `start_i && ALUCtrl_i==MUL && !flush_i`.
  - On trigger: latch `mcand<=data1_i`, `mplier<=data2_i`, `acc<=0`, `cnt<=0`; go to RUN.
  - Any other code: remain in IDLE.
- **RUN**, each cycle:
  - If `mplier[0]`: `acc<=acc+mcand`, modulo 2^WIDTH.
  - `mcand<=mcand<<1`, `mplier<=mplier>>1` (logical), `cnt<=cnt+1`.
  - When `cnt==WIDTH-1`: load `result_o` with the final sum for this step, then go to DONE.
  - The multiplier always runs WIDTH iterations; there is no early exit on a zero multiplier.
- **DONE**
  - `done_o=1`; go to IDLE.
  - `start_i` is ignored in DONE. The stalled instruction is still present in EX this cycle and must not retrigger.
- Arithmetic: the low WIDTH product bits are identical for signed and unsigned two's-complement operands, so no sign handling is needed.
- `stall_o` (combinational) = `!rst_i && !flush_i && ((IDLE && trigger) || RUN)`.
- `busy_o` = RUN. `done_o` = DONE.
- `flush_i` in any state: next state IDLE, `acc`/`cnt` discarded, no `done_o`, `result_o` unchanged. Same-cycle `flush_i` and trigger: no start.
- `rst_i` has priority over everything.
  - State returns to IDLE.
  - `result_o`, `acc`, `cnt`, `mcand`, `mplier` are cleared to 0.
  - `stall_o`, `busy_o`, `done_o` are 0 while `rst_i` is high and in the cycle after.
- Reset mid-RUN: the operation is dropped with no `done_o`.

## Timing
- Cycle 0 (IDLE, trigger): `stall_o=1`; operands latched at the edge.
- Cycles 1..WIDTH (RUN): `stall_o=1`, `busy_o=1`.
- Cycle WIDTH+1 (DONE): `stall_o=0`, `done_o=1`, `result_o` valid; the pipeline advances at the end of this cycle.
- Totals: `stall_o` is high for WIDTH+1 consecutive cycles per MUL; the MUL occupies EX for WIDTH+2 cycles (33 stall cycles, 34 in EX for WIDTH=32).
- Back-to-back MUL: the second MUL reaches EX in the cycle after DONE and triggers from IDLE with no gap cycle.
- `result_o` holds its value until the next DONE or reset.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - ALU control constants: `ALU_NOP=3'b000`, `ALU_ADD=3'b001`, `ALU_SUB=3'b010`, `ALU_AND=3'b011`, `ALU_OR=3'b100`, `ALU_MUL=3'b101`.
  - The `mul_state_t` enum (IDLE/RUN/DONE).
  - The ALU control decoder uses the same constants.
- One sub-module, `mul_shift_add_dp`:
  - Contains the `mcand`, `mplier` and `acc` registers plus the adder.
  - Controls: `load`, `step`, `clear`.
  - Output: `acc_next`.
- The FSM, counter and `result_o` register stay in `mul_sequencer`.

## Test plan
- **Basic multiply:** MUL with data1=3, data2=5 → `stall_o` high exactly 33 cycles, `done_o` pulses once in cycle 33, `result_o`=15.
- **Wrap-around:** MUL 0xFFFFFFFF×0xFFFFFFFF → `result_o`=0x00000001. MUL 0x80000000×2 → `result_o`=0x00000000.
- **No stall for other ops:** `start_i`=1 with ALUCtrl=ADD, then OR, then NOP → `stall_o`, `busy_o`, `done_o` stay 0; `result_o` unchanged.
- **Flush mid-run:** MUL 7×9, `flush_i` in RUN cycle 10 → `stall_o`=0 from the next cycle, no `done_o`, `result_o` keeps its prior value (e.g. 15).
- **Back-to-back:** MUL 2×3 then MUL 4×4 → `done_o` with 6 in cycle 33, the second trigger in cycle 34, `done_o` with 16 in cycle 67. No retrigger from the DONE cycle.
- **Reset mid-run:** `rst_i` high in RUN cycle 5 → all outputs 0 the next cycle, state IDLE, no `done_o`; a fresh MUL 3×5 afterwards completes normally with 15.
